codec_bringup_seq: RTL and testbench
====================================

// Module: codec_bringup_seq
// PURPOSE
// - Power-up/recovery sequencer for the AK4619 codec path: drives PDN, triggers the I2C register-init engine, gates the audio clocks (BICK/LRCK), and releases mute on a frame boundary.
// - Sits between the top-level clock divider and i2cinit. Replaces free-running bring-up with a checked, retryable sequence.
// PARAMETERS
// - PDN_LOW_CYCLES   1200    clk cycles PDN held low (100 us @ 12 MHz)
// - PDN_SETTLE_CYC   12000   clk cycles after PDN high before I2C start
// - I2C_TIMEOUT_CYC  120000  max clk cycles waiting for i2c_done
// - MAX_RETRIES      3       failed init attempts before FAULT latches
// - MUTE_FRAMES      4       frame_sync pulses with audio_en before unmute
// PORTS
// - clk          in   1  system clock (12 MHz, also MCLK)
// - rst_n        in   1  async active-low reset
// - restart      in   1  1-cycle pulse: re-run full sequence from any state
// - i2c_done     in   1  1-cycle pulse from init engine: all writes completed
// - i2c_nack     in   1  1-cycle pulse from init engine: slave NACK, aborted
// - frame_sync   in   1  1-cycle pulse on each LRCK rising edge (clk domain)
// - pdn          out  1  codec power-down pin, 0 = powered down
// - i2c_start    out  1  1-cycle pulse launching register init
// - audio_en     out  1  enables BICK/LRCK/SDIN generation
// - mute         out  1  1 = force SDIN samples to zero
// - ready        out  1  1 in RUN only
// - fault        out  1  1 in FAULT only
// - retry_cnt    out  2  failed attempts so far in this sequence
// BEHAVIOUR
// - Reset (async): state=PDN_LOW, timer loaded PDN_LOW_CYCLES-1, pdn=0, i2c_start=0, audio_en=0, mute=1, ready=0, fault=0, retry_cnt=0.
// - States/transitions (all registered outputs, decoded from state):
//   PDN_LOW : pdn=0; timer expires -> PDN_SETTLE (load PDN_SETTLE_CYC-1).
//   PDN_SETTLE: pdn=1; expires -> I2C_KICK.
//   I2C_KICK: i2c_start=1 for exactly this one cycle -> I2C_WAIT (load I2C_TIMEOUT_CYC-1).
//   I2C_WAIT: i2c_done -> AUDIO_ON (frame counter=0); i2c_nack or timer expiry -> RETRY.
//     done and nack same cycle: nack wins.
//   RETRY   : retry_cnt+1; if new count == MAX_RETRIES -> FAULT else -> PDN_LOW (full power cycle).
//   AUDIO_ON: audio_en=1, mute=1; count frame_sync; on MUTE_FRAMES-th pulse -> RUN.
//   RUN     : audio_en=1, mute=0, ready=1; stays until restart.
//   FAULT   : pdn=0, audio_en=0, mute=1, fault=1; only restart or reset exits.
// - Timer: down-counter, "expires" on the cycle it reads 0; state dwell = N cycles exactly.
// - restart (any state, incl. mid-wait): next cycle state=PDN_LOW, timer reloaded, retry_cnt=0, outputs as reset. restart has priority over every other event same cycle.
// - i2c_done/i2c_nack outside I2C_WAIT: ignored. frame_sync outside AUDIO_ON: ignored.
// - mute deasserts in the same cycle audio-side sees RUN, i.e. the cycle after the last counted frame_sync -> first unmuted sample is a whole frame.
// - Timer width = $clog2(max of timing params); retry_cnt saturates, never wraps.
// STRUCTURE
// - Package codec_seq_pkg: state enum (PDN_LOW, PDN_SETTLE, I2C_KICK, I2C_WAIT, RETRY, AUDIO_ON, RUN, FAULT), default timing constants.
// - Sub-module seq_timer #(W): load/value/expired down-counter, reused for all dwell/timeout phases.
// - FSM, retry counter, frame counter in this module; no other hierarchy.
// TESTING (bench overrides timing: PDN_LOW=4, SETTLE=8, TIMEOUT=20, MUTE_FRAMES=2)
// - Nominal: release rst_n, i2c_done 5 cycles after i2c_start -> pdn rises cycle 4, i2c_start pulse at cycle 12, ready after 2nd frame_sync, mute=0.
// - Timeout: never pulse i2c_done -> 3 full PDN cycles, retry_cnt 1,2,3, fault=1, pdn=0, audio_en=0.
// - NACK then success: nack on attempt 1, done on attempt 2 -> retry_cnt=1, ready=1.
// - Simultaneous done+nack in I2C_WAIT -> treated as NACK, retry_cnt increments.
// - restart in RUN and in FAULT -> next cycle pdn=0, mute=1, retry_cnt=0; sequence repeats.
// - Async reset asserted mid-I2C_WAIT (off clk edge) -> outputs reach reset values immediately.

Source files
------------

// File: rtl/codec_bringup_seq_pkg.sv
// Shared types and default timing for the AK4619 bring-up sequencer.
package codec_seq_pkg;

   // Default timing at 12 MHz clk_sys/MCLK.
   localparam int unsigned DEF_PDN_LOW_CYCLES  = 1200;
   localparam int unsigned DEF_PDN_SETTLE_CYC  = 12000;
   localparam int unsigned DEF_I2C_TIMEOUT_CYC = 120000;
   localparam int unsigned DEF_MAX_RETRIES     = 3;
   localparam int unsigned DEF_MUTE_FRAMES     = 4;

   typedef enum logic [2:0] {
      PDN_LOW,
      PDN_SETTLE,
      I2C_KICK,
      I2C_WAIT,
      RETRY,
      AUDIO_ON,
      RUN,
      FAULT
   } seq_state_t;

   typedef struct packed {
      logic pdn;
      logic i2c_start;
      logic audio_en;
      logic mute;
      logic ready;
      logic fault;
   } seq_out_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Output levels owned by each state; mute stays on everywhere except RUN.
   function automatic seq_out_t decode_outputs(input seq_state_t s);
      seq_out_t o;
      o = '{pdn: 1'b0, i2c_start: 1'b0, audio_en: 1'b0, mute: 1'b1, ready: 1'b0, fault: 1'b0};
      case (s)
         PDN_LOW: ;
         PDN_SETTLE: o.pdn = 1'b1;
         I2C_KICK: begin
            o.pdn       = 1'b1;
            o.i2c_start = 1'b1;
         end
         I2C_WAIT, RETRY: o.pdn = 1'b1;
         AUDIO_ON: begin
            o.pdn      = 1'b1;
            o.audio_en = 1'b1;
         end
         RUN: begin
            o.pdn      = 1'b1;
            o.audio_en = 1'b1;
            o.mute     = 1'b0;
            o.ready    = 1'b1;
         end
         FAULT: o.fault = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/codec_bringup_seq_timer.sv
// Load/decrement dwell timer; expired while the count reads zero.
module seq_timer #(
   parameter int unsigned     W         = 8,
   parameter logic [W-1:0]    RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_value,
   output logic         o_expired
);

   logic [W-1:0] r_value;

   // Load wins over decrement; the count parks at zero until reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= RESET_VAL;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (r_value != '0) begin
         r_value <= r_value - 1'b1;
      end
   end

   assign o_value   = r_value;
   assign o_expired = (r_value == '0);

endmodule

// File: rtl/codec_bringup_seq.sv
// Power-up / recovery sequencer for the AK4619 codec path.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PDN_LOW    | codec held in power-down for PDN_LOW_CYCLES
// PDN_SETTLE | PDN released, waiting PDN_SETTLE_CYC before register init
// I2C_KICK   | one-cycle i2c_start pulse to the init engine
// I2C_WAIT   | waiting for done/nack, bounded by I2C_TIMEOUT_CYC
// RETRY      | one cycle: decide power-cycle retry or give up
// AUDIO_ON   | audio clocks running, muted, counting frame_sync pulses
// RUN        | unmuted, ready; left only by restart
// FAULT      | init failed MAX_RETRIES times; left only by restart/reset
module codec_bringup_seq
   import codec_seq_pkg::*;
#(
   parameter int unsigned PDN_LOW_CYCLES  = DEF_PDN_LOW_CYCLES,
   parameter int unsigned PDN_SETTLE_CYC  = DEF_PDN_SETTLE_CYC,
   parameter int unsigned I2C_TIMEOUT_CYC = DEF_I2C_TIMEOUT_CYC,
   // retry_cnt is 2 bits wide and saturates at 3, so keep this at 1..3.
   parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
   parameter int unsigned MUTE_FRAMES     = DEF_MUTE_FRAMES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       restart,
   input  logic       i2c_done,
   input  logic       i2c_nack,
   input  logic       frame_sync,
   output logic       pdn,
   output logic       i2c_start,
   output logic       audio_en,
   output logic       mute,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt
);

   localparam int unsigned TMR_MAX = max3(PDN_LOW_CYCLES, PDN_SETTLE_CYC, I2C_TIMEOUT_CYC);
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned FRM_W   = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;

   localparam logic [TMR_W-1:0] LD_PDN_LOW  = TMR_W'(PDN_LOW_CYCLES - 1);
   localparam logic [TMR_W-1:0] LD_SETTLE   = TMR_W'(PDN_SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] LD_I2C_WAIT = TMR_W'(I2C_TIMEOUT_CYC - 1);
   localparam logic [FRM_W-1:0] FRM_LAST    = FRM_W'(MUTE_FRAMES - 1);

   seq_state_t       r_state;
   seq_state_t       w_next_state;
   seq_out_t         r_out;
   logic [1:0]       r_retry_cnt;
   logic [FRM_W-1:0] r_frame_cnt;

   logic             w_enter;
   logic             w_tmr_load;
   logic [TMR_W-1:0] w_tmr_load_val;
   logic [TMR_W-1:0] w_tmr_value;
   logic             w_tmr_expired;
   logic             w_attempt_failed;

   seq_timer #(
      .W         (TMR_W),
      .RESET_VAL (LD_PDN_LOW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_load_val),
      .o_value    (w_tmr_value),
      .o_expired  (w_tmr_expired)
   );

   // Next-state decision; restart overrides every other event.
   always_comb begin
      w_next_state = r_state;
      if (restart) begin
         w_next_state = PDN_LOW;
      end else begin
         case (r_state)
            PDN_LOW:    if (w_tmr_expired) w_next_state = PDN_SETTLE;
            PDN_SETTLE: if (w_tmr_expired) w_next_state = I2C_KICK;
            I2C_KICK:   w_next_state = I2C_WAIT;
            I2C_WAIT: begin
               // nack beats done; a done arriving on the last timeout cycle still counts.
               if (i2c_nack)           w_next_state = RETRY;
               else if (i2c_done)      w_next_state = AUDIO_ON;
               else if (w_tmr_expired) w_next_state = RETRY;
            end
            RETRY: begin
               if (32'(r_retry_cnt) >= MAX_RETRIES) w_next_state = FAULT;
               else                                 w_next_state = PDN_LOW;
            end
            AUDIO_ON:   if (frame_sync && (r_frame_cnt == FRM_LAST)) w_next_state = RUN;
            RUN:        w_next_state = RUN;
            FAULT:      w_next_state = FAULT;
            default:    w_next_state = PDN_LOW;
         endcase
      end
   end

   assign w_attempt_failed = !restart && (r_state == I2C_WAIT) && (w_next_state == RETRY);

   // Reload the timer whenever a timed phase is entered (restart re-enters PDN_LOW).
   always_comb begin
      w_enter        = restart || (w_next_state != r_state);
      w_tmr_load     = 1'b0;
      w_tmr_load_val = LD_PDN_LOW;
      if (w_enter) begin
         case (w_next_state)
            PDN_LOW: begin
               w_tmr_load     = 1'b1;
               w_tmr_load_val = LD_PDN_LOW;
            end
            PDN_SETTLE: begin
               w_tmr_load     = 1'b1;
               w_tmr_load_val = LD_SETTLE;
            end
            I2C_WAIT: begin
               w_tmr_load     = 1'b1;
               w_tmr_load_val = LD_I2C_WAIT;
            end
            default: ;
         endcase
      end
   end

   // State, registered outputs, retry and frame counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= PDN_LOW;
         r_out       <= decode_outputs(PDN_LOW);
         r_retry_cnt <= 2'd0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         r_out   <= decode_outputs(w_next_state);

         // Counted on entry to RETRY so the RETRY cycle already shows the new total.
         if (restart) begin
            r_retry_cnt <= 2'd0;
         end else if (w_attempt_failed && (r_retry_cnt != 2'b11)) begin
            r_retry_cnt <= r_retry_cnt + 2'd1;
         end

         if ((w_next_state == AUDIO_ON) && (r_state != AUDIO_ON)) begin
            r_frame_cnt <= '0;
         end else if ((r_state == AUDIO_ON) && frame_sync && !restart) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   // The I2C watchdog must never hold more than its own timeout while waiting.
   a_wait_timer_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == I2C_WAIT) |-> (w_tmr_value <= LD_I2C_WAIT));

   assign pdn       = r_out.pdn;
   assign i2c_start = r_out.i2c_start;
   assign audio_en  = r_out.audio_en;
   assign mute      = r_out.mute;
   assign ready     = r_out.ready;
   assign fault     = r_out.fault;
   assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_codec_bringup_seq.sv
// Bench for codec_bringup_seq with shortened timing.
module tb_codec_bringup_seq;

   localparam int T_LOW   = 4;
   localparam int T_SET   = 8;
   localparam int T_TO    = 20;
   localparam int MAXR    = 3;
   localparam int MUTE_FR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       restart = 1'b0;
   logic       i2c_done = 1'b0;
   logic       i2c_nack = 1'b0;
   logic       frame_sync = 1'b0;
   logic       pdn, i2c_start, audio_en, mute, ready, fault;
   logic [1:0] retry_cnt;

   int n_checks = 0;
   int n_errors = 0;

   codec_bringup_seq #(
      .PDN_LOW_CYCLES  (T_LOW),
      .PDN_SETTLE_CYC  (T_SET),
      .I2C_TIMEOUT_CYC (T_TO),
      .MAX_RETRIES     (MAXR),
      .MUTE_FRAMES     (MUTE_FR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (restart),
      .i2c_done   (i2c_done),
      .i2c_nack   (i2c_nack),
      .frame_sync (frame_sync),
      .pdn        (pdn),
      .i2c_start  (i2c_start),
      .audio_en   (audio_en),
      .mute       (mute),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt)
   );

   always #5 clk = ~clk;

   // Output word: {pdn, i2c_start, audio_en, mute, ready, fault, retry_cnt[1:0]}
   function automatic logic [7:0] pk(input logic p, input logic s, input logic a,
                                     input logic m, input logic r, input logic f,
                                     input int rc);
      return {p, s, a, m, r, f, 2'(rc)};
   endfunction

   function automatic logic [7:0] e_low(input int rc);    return pk(0,0,0,1,0,0,rc); endfunction
   function automatic logic [7:0] e_settle(input int rc); return pk(1,0,0,1,0,0,rc); endfunction
   function automatic logic [7:0] e_kick(input int rc);   return pk(1,1,0,1,0,0,rc); endfunction
   function automatic logic [7:0] e_wait(input int rc);   return pk(1,0,0,1,0,0,rc); endfunction
   function automatic logic [7:0] e_audio(input int rc);  return pk(1,0,1,1,0,0,rc); endfunction
   function automatic logic [7:0] e_run(input int rc);    return pk(1,0,1,0,1,0,rc); endfunction
   function automatic logic [7:0] e_fault(input int rc);  return pk(0,0,0,1,0,1,rc); endfunction

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {pdn, i2c_start, audio_en, mute, ready, fault, retry_cnt};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got pdn,start,aud,mute,rdy,flt,rc=%b required %b (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold the given pulses for one edge, then advance to adv edges in total.
   task automatic apply(input logic rs, input logic dn, input logic nk, input logic fs,
                        input int adv);
      if (adv > 0) begin
         restart = rs; i2c_done = dn; i2c_nack = nk; frame_sync = fs;
         tick();
         restart = 0; i2c_done = 0; i2c_nack = 0; frame_sync = 0;
         repeat (adv - 1) tick();
      end
   endtask

   task automatic step_chk(input string name, input logic rs, input logic dn, input logic nk,
                           input logic fs, input int adv, input logic [7:0] exp);
      apply(rs, dn, nk, fs, adv);
      check(name, exp);
   endtask

   // Reference model: phase plus cycles spent in it, advanced once per clock edge.
   typedef enum {M_OFF, M_SETTLE, M_KICK, M_WAIT, M_RETRY, M_AUDIO, M_RUN, M_FAULT} mph_t;
   mph_t m_ph;
   int   m_el, m_rc, m_frames;

   function automatic logic [7:0] m_out();
      case (m_ph)
         M_OFF:    return e_low(m_rc);
         M_SETTLE: return e_settle(m_rc);
         M_KICK:   return e_kick(m_rc);
         M_WAIT:   return e_wait(m_rc);
         M_RETRY:  return e_wait(m_rc);
         M_AUDIO:  return e_audio(m_rc);
         M_RUN:    return e_run(m_rc);
         default:  return e_fault(m_rc);
      endcase
   endfunction

   task automatic m_fail();
      m_rc = (m_rc < 3) ? m_rc + 1 : 3;
      m_ph = M_RETRY;
   endtask

   task automatic m_step(input logic rs, input logic dn, input logic nk, input logic fs);
      if (rs) begin
         m_ph = M_OFF; m_el = 0; m_rc = 0;
      end else begin
         case (m_ph)
            M_OFF: begin
               m_el++;
               if (m_el == T_LOW) begin m_ph = M_SETTLE; m_el = 0; end
            end
            M_SETTLE: begin
               m_el++;
               if (m_el == T_SET) begin m_ph = M_KICK; m_el = 0; end
            end
            M_KICK: begin m_ph = M_WAIT; m_el = 0; end
            M_WAIT: begin
               if (nk) m_fail();
               else if (dn) begin m_ph = M_AUDIO; m_frames = 0; end
               else begin
                  m_el++;
                  if (m_el == T_TO) m_fail();
               end
            end
            M_RETRY: begin
               m_ph = (m_rc >= MAXR) ? M_FAULT : M_OFF;
               m_el = 0;
            end
            M_AUDIO: if (fs) begin
               m_frames++;
               if (m_frames == MUTE_FR) m_ph = M_RUN;
            end
            default: ;
         endcase
      end
   endtask

   typedef struct {
      string      name;
      logic       rs, dn, nk, fs;
      int         adv;
      logic [7:0] exp;
   } vec_t;

   vec_t tv[$];

   initial begin
      // Nominal bring-up, then nack-then-success after a restart from RUN.
      tv.push_back('{"reset",         0,0,0,0,  0, e_low(0)});
      tv.push_back('{"plow_end",      0,0,0,0,  3, e_low(0)});
      tv.push_back('{"pdn_rise_c4",   0,0,0,0,  1, e_settle(0)});
      tv.push_back('{"settle_end",    0,0,0,0,  7, e_settle(0)});
      tv.push_back('{"kick_c12",      0,0,0,0,  1, e_kick(0)});
      tv.push_back('{"kick_one_cyc",  0,0,0,0,  1, e_wait(0)});
      tv.push_back('{"wait_idle",     0,0,0,0,  3, e_wait(0)});
      tv.push_back('{"done",          0,1,0,0,  1, e_audio(0)});
      tv.push_back('{"frame1_muted",  0,0,0,1,  1, e_audio(0)});
      tv.push_back('{"frame_gap",     0,0,0,0,  3, e_audio(0)});
      tv.push_back('{"frame2_run",    0,0,0,1,  1, e_run(0)});
      tv.push_back('{"run_ignores",   0,1,1,1,  2, e_run(0)});
      tv.push_back('{"restart_run",   1,0,0,0,  1, e_low(0)});
      tv.push_back('{"fs_ign_kick",   0,0,0,1, 12, e_kick(0)});
      tv.push_back('{"nack_in_kick",  0,0,1,0,  1, e_wait(0)});
      tv.push_back('{"nack_retry",    0,0,1,0,  1, e_wait(1)});
      tv.push_back('{"retry_to_plow", 0,0,0,0,  1, e_low(1)});
      tv.push_back('{"att2_kick",     0,0,0,0, 12, e_kick(1)});
      tv.push_back('{"att2_wait",     0,0,0,0,  1, e_wait(1)});
      tv.push_back('{"att2_done",     0,1,0,0,  1, e_audio(1)});
      tv.push_back('{"att2_frame1",   0,0,0,1,  1, e_audio(1)});
      tv.push_back('{"att2_run",      0,0,0,1,  1, e_run(1)});

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (tv[i]) step_chk(tv[i].name, tv[i].rs, tv[i].dn, tv[i].nk, tv[i].fs,
                               tv[i].adv, tv[i].exp);

      // Simultaneous done and nack counts as a nack.
      step_chk("sim_restart", 1,0,0,0,  1, e_low(0));
      step_chk("sim_to_wait", 0,0,0,0, 13, e_wait(0));
      step_chk("sim_dn_nk",   0,1,1,0,  1, e_wait(1));
      step_chk("sim_plow",    0,0,0,0,  1, e_low(1));

      // Three timeouts in a row latch FAULT.
      step_chk("to_restart",  1,0,0,0,  1, e_low(0));
      for (int a = 1; a <= 3; a++) begin
         step_chk($sformatf("to%0d_kick", a),     0,0,0,0, 12, e_kick(a - 1));
         step_chk($sformatf("to%0d_wait", a),     0,0,0,0,  1, e_wait(a - 1));
         step_chk($sformatf("to%0d_lastwait", a), 0,0,0,0, 19, e_wait(a - 1));
         step_chk($sformatf("to%0d_retry", a),    0,0,0,0,  1, e_wait(a));
         step_chk($sformatf("to%0d_after", a),    0,0,0,0,  1,
                  (a < 3) ? e_low(a) : e_fault(3));
      end
      step_chk("fault_holds",   0,1,1,1,  5, e_fault(3));
      step_chk("fault_restart", 1,0,0,0,  1, e_low(0));
      step_chk("rerun_kick",    0,0,0,0, 12, e_kick(0));

      // Async reset in the middle of I2C_WAIT with a non-zero retry count.
      step_chk("ar_wait",  0,0,0,0,  1, e_wait(0));
      step_chk("ar_nack",  0,0,1,0,  1, e_wait(1));
      step_chk("ar_plow",  0,0,0,0,  1, e_low(1));
      step_chk("ar_kick",  0,0,0,0, 12, e_kick(1));
      step_chk("ar_wait2", 0,0,0,0,  5, e_wait(1));
      #3 rst_n = 1'b0;
      #1 check("async_rst_now", e_low(0));
      tick();
      check("async_rst_held", e_low(0));
      rst_n = 1'b1;

      // Randomised traffic against the reference model.
      m_ph = M_OFF; m_el = 0; m_rc = 0; m_frames = 0;
      for (int i = 0; i < 3000; i++) begin
         logic rs, dn, nk, fs;
         rs = ($urandom_range(0, 199) == 0);
         dn = ($urandom_range(0, 7) == 0);
         nk = ($urandom_range(0, 29) == 0);
         fs = ($urandom_range(0, 2) == 0);
         restart = rs; i2c_done = dn; i2c_nack = nk; frame_sync = fs;
         tick();
         m_step(rs, dn, nk, fs);
         check($sformatf("rand%0d", i), m_out());
      end
      restart = 0; i2c_done = 0; i2c_nack = 0; frame_sync = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
